// File: rtl/alu_div_seq.sv
// rtl/alu_div_seq.sv - multi-cycle restoring divider for DIV/DIVU, HI=remainder, LO=quotient
module alu_div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_q, r_d, r_dvd;
    logic [WIDTH:0]     r_r;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_q, r_neg_r, r_dz;
    logic [WIDTH-1:0]   r_quotient, r_remainder;
    logic               r_div_by_zero;

    logic               w_accept, w_last;
    logic               w_dvd_neg, w_dvs_neg;
    logic [WIDTH-1:0]   w_dvd_mag, w_dvs_mag;
    logic [WIDTH:0]     w_rs, w_t, w_r_nx;
    logic [WIDTH-1:0]   w_q_nx, w_q_fin, w_r_fin;

    assign w_accept  = start && (r_state != S_RUN);
    assign w_last    = (r_cnt == CNT_W'(WIDTH-1));
    assign w_dvd_neg = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg = is_signed & divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag = w_dvs_neg ? -divisor : divisor;

    // One restoring step: shift {R,Q} left, keep the trial difference if it did not borrow.
    assign w_rs   = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_t    = w_rs - {1'b0, r_d};
    assign w_r_nx = w_t[WIDTH] ? w_rs : w_t;
    assign w_q_nx = {r_q[WIDTH-2:0], ~w_t[WIDTH]};

    assign w_q_fin = r_neg_q ? -w_q_nx : w_q_nx;
    assign w_r_fin = r_neg_r ? -w_r_nx[WIDTH-1:0] : w_r_nx[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q           <= '0;
            r_d           <= '0;
            r_dvd         <= '0;
            r_r           <= '0;
            r_cnt         <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_dz          <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_q     <= w_dvd_mag;
            r_d     <= w_dvs_mag;
            r_dvd   <= dividend;
            r_r     <= '0;
            r_cnt   <= '0;
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
            r_dz    <= (divisor == '0);
        end else if (r_state == S_RUN) begin
            r_q   <= w_q_nx;
            r_r   <= w_r_nx;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                // Divide-by-zero still runs the full latency but reports a fixed result.
                r_quotient    <= r_dz ? '1 : w_q_fin;
                r_remainder   <= r_dz ? r_dvd : w_r_fin;
                r_div_by_zero <= r_dz;
            end
        end
    end

    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
